// File: rtl/decode_pipe_stage.sv
// decode_pipe_stage: register file with bypass, RAW hazard stall and ID/EX pipeline register
module decode_pipe_stage #(
  parameter int DATA_W = 16,
  parameter int NREG = 8,
  parameter int FWD = 1,
  parameter int CNT_W = 16,
  localparam int AW = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid,
  input  logic [15:0]       if_instr,
  input  logic [DATA_W-1:0] if_pc,
  output logic              id_ready,
  input  logic [AW-1:0]     rs_sel,
  input  logic [AW-1:0]     rt_sel,
  input  logic              rs_used,
  input  logic              rt_used,
  input  logic [AW-1:0]     wr_sel,
  input  logic              wr_en,
  input  logic              is_load,
  input  logic              mem_valid,
  input  logic              mem_wr_en,
  input  logic [AW-1:0]     mem_wr_sel,
  input  logic              wb_en,
  input  logic [AW-1:0]     wb_sel,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              flush,
  input  logic              ex_ready,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [15:0]       ex_instr,
  output logic [DATA_W-1:0] ex_pc,
  output logic [AW-1:0]     ex_wr_sel,
  output logic              ex_wr_en,
  output logic              ex_is_load,
  output logic [CNT_W-1:0]  stall_cnt
);
  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];
  logic [DATA_W-1:0] rs_data, rt_data;
  logic              ex_valid_q, ex_valid_d, ex_wr_en_q, ex_wr_en_d, ex_is_load_q, ex_is_load_d;
  logic [DATA_W-1:0] ex_rs_data_q, ex_rs_data_d, ex_rt_data_q, ex_rt_data_d, ex_pc_q, ex_pc_d;
  logic [15:0]       ex_instr_q, ex_instr_d;
  logic [AW-1:0]     ex_wr_sel_q, ex_wr_sel_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic              ex_we, mem_we, hazard, hold;
  // Write-back into the register file and bypassed combinational reads
  always_comb begin
    regs_d = regs_q;
    if (wb_en) regs_d[wb_sel] = wb_data;
    rs_data = (wb_en && wb_sel == rs_sel) ? wb_data : regs_q[rs_sel];
    rt_data = (wb_en && wb_sel == rt_sel) ? wb_data : regs_q[rt_sel];
  end
  // Hazard detection: with forwarding only a load in ID/EX stalls; without it EX and MEM writers stall
  always_comb begin
    ex_we = ex_valid_q & ex_wr_en_q & (FWD != 0 ? ex_is_load_q : 1'b1);
    mem_we = (FWD == 0) & mem_valid & mem_wr_en;
    hazard = if_valid & (
      (rs_used & ex_we & (ex_wr_sel_q == rs_sel)) | (rt_used & ex_we & (ex_wr_sel_q == rt_sel)) |
      (rs_used & mem_we & (mem_wr_sel == rs_sel)) | (rt_used & mem_we & (mem_wr_sel == rt_sel)));
    hold = ex_valid_q & ~ex_ready;
    id_ready = flush | (~hazard & ~hold);
  end
  // ID/EX next state: flush beats hold beats bubble beats load; saturating stall counter
  always_comb begin
    ex_valid_d = ex_valid_q;
    ex_wr_en_d = ex_wr_en_q;
    ex_is_load_d = ex_is_load_q;
    ex_rs_data_d = ex_rs_data_q;
    ex_rt_data_d = ex_rt_data_q;
    ex_pc_d = ex_pc_q;
    ex_instr_d = ex_instr_q;
    ex_wr_sel_d = ex_wr_sel_q;
    if (flush) ex_valid_d = 1'b0;
    else if (!hold && hazard) begin
      ex_valid_d = 1'b0;
      ex_wr_en_d = 1'b0;
      ex_is_load_d = 1'b0;
    end else if (!hold) begin
      ex_valid_d = if_valid;
      ex_wr_en_d = wr_en;
      ex_is_load_d = is_load;
      ex_rs_data_d = rs_data;
      ex_rt_data_d = rt_data;
      ex_pc_d = if_pc;
      ex_instr_d = if_instr;
      ex_wr_sel_d = wr_sel;
    end
    stall_cnt_d = stall_cnt_q + CNT_W'(hazard & ~flush & ~hold & ~&stall_cnt_q);
  end
  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q <= '{default: '0};
      ex_valid_q <= 1'b0;
      ex_wr_en_q <= 1'b0;
      ex_is_load_q <= 1'b0;
      ex_rs_data_q <= '0;
      ex_rt_data_q <= '0;
      ex_pc_q <= '0;
      ex_instr_q <= '0;
      ex_wr_sel_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      regs_q <= regs_d;
      ex_valid_q <= ex_valid_d;
      ex_wr_en_q <= ex_wr_en_d;
      ex_is_load_q <= ex_is_load_d;
      ex_rs_data_q <= ex_rs_data_d;
      ex_rt_data_q <= ex_rt_data_d;
      ex_pc_q <= ex_pc_d;
      ex_instr_q <= ex_instr_d;
      ex_wr_sel_q <= ex_wr_sel_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end
  assign ex_valid = ex_valid_q;
  assign ex_wr_en = ex_wr_en_q;
  assign ex_is_load = ex_is_load_q;
  assign ex_rs_data = ex_rs_data_q;
  assign ex_rt_data = ex_rt_data_q;
  assign ex_pc = ex_pc_q;
  assign ex_instr = ex_instr_q;
  assign ex_wr_sel = ex_wr_sel_q;
  assign stall_cnt = stall_cnt_q;
endmodule

// File: doc/decode_pipe_stage.md
Name: decode_pipe_stage

Overview:
Parametrised pipelined successor to the single-cycle decode stage. It holds the architectural register file with write-through bypass and detects RAW hazards against in-flight instructions. It generates fetch stall/bubble insertion, honours branch flush, and registers all operands into an ID/EX pipeline register with a valid/ready handshake. A separate control unit decodes the opcode; this block consumes the control unit's pre-decoded register selects.

Parameters:
DATA_W, 16, register/operand/PC width
NREG, 8, number of registers (power of two, ≥2); AW = clog2(NREG)
FWD, 1, 1 = EX forwarding exists, stall only on load-use; 0 = no forwarding, stall on any RAW until writeback
CNT_W, 16, width of stall performance counter

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
if_valid  in  1  fetch presents an instruction
if_instr  in  16  instruction word
if_pc  in  DATA_W  PC+2 of instruction
id_ready  out  1  decode accepts if_* this cycle
rs_sel, rt_sel  in  AW  source register selects (from control)
rs_used, rt_used  in  1  source actually read
wr_sel  in  AW  destination register
wr_en  in  1  instruction writes a register
is_load  in  1  instruction is a memory load
mem_valid, mem_wr_en  in  1  MEM-stage instruction valid / writes a register
mem_wr_sel  in  AW  MEM-stage destination
wb_en  in  1  writeback enable
wb_sel  in  AW  writeback register
wb_data  in  DATA_W  writeback data
flush  in  1  kill decode and ID/EX contents (taken branch/jump)
ex_ready  in  1  EX accepts ID/EX contents
ex_valid  out  1  ID/EX register holds a live instruction
ex_rs_data, ex_rt_data  out  DATA_W  operands
ex_instr  out  16  instruction
ex_pc  out  DATA_W  PC
ex_wr_sel  out  AW; ex_wr_en, ex_is_load  out  1  forwarded control
stall_cnt  out  CNT_W  cycles with hazard stall, saturating

Behaviour:
- Reset: all NREG registers = 0. ex_valid = 0. All ex_* data/control = 0. stall_cnt = 0. id_ready is combinational and equals 1 after reset.
- Register file: written on clk edge when wb_en. Reads are combinational with bypass: if wb_en and wb_sel == read select, the read returns wb_data the same cycle.
- match(s) = s_used & v & we & (sel == s_sel), evaluated for s ∈ {rs, rt}.
- hazard with FWD=1: match against the ID/EX register, with v = ex_valid, we = ex_wr_en & ex_is_load, sel = ex_wr_sel.
- hazard with FWD=0: OR of the match against the ID/EX register (v = ex_valid, we = ex_wr_en) and the match against MEM (v = mem_valid, we = mem_wr_en, sel = mem_wr_sel). The WB stage is covered by bypass.
- hazard is qualified by if_valid. hold = ex_valid & ~ex_ready.
- id_ready = flush | (~hazard & ~hold).
- ID/EX update priority each edge:
  1. rst
  2. flush → ex_valid ← 0 (data don't-care); the fetched instruction is dropped
  3. hold → all ex_* retained
  4. hazard → bubble: ex_valid ← 0, ex_wr_en ← 0, ex_is_load ← 0
  5. otherwise ex_valid ← if_valid and all ex_* loaded from current decode (bypassed reads)
- Latency: one cycle from acceptance to ex_valid.
- Flush has priority over hold: ex is killed even when ex_ready = 0.
- Load-use (FWD=1) costs exactly one bubble, because the load then leaves ID/EX.
- stall_cnt increments on each cycle with if_valid & hazard & ~flush & ~hold. It saturates at all-ones and never wraps.
- A simultaneous wb to a register being stalled on clears the hazard only when it clears the pipeline match; bypass alone does not clear the match.
- Reset mid-stall discards the ID/EX contents and the counter.

Test Plan:
- Reset, then wb R3=16'h1234 with a simultaneous read of R3 → ex_rs_data=16'h1234 one cycle later, ex_valid=1.
- FWD=1: load writing R2 in ID/EX, next instruction reads R2 → id_ready=0 for 1 cycle, one bubble (ex_valid=0), then accepted; stall_cnt=1.
- FWD=1: ALU op writing R2 followed by a reader of R2 → no stall, back-to-back ex_valid=1.
- FWD=0: writer of R5 followed by a reader of R5 → 2 stall cycles (EX, then MEM), accepted when the wb bypass supplies the value; stall_cnt=2.
- ex_ready=0 for 3 cycles → ex_* held, id_ready=0. Flush during the hold → ex_valid=0 next edge, id_ready=1.
- CNT_W=2, 5 stall cycles → stall_cnt saturates at 3.
